// File: rtl/imgproc_pkg.sv
// imgproc_pkg: definitions shared by the image pipeline sequencer, its stage
// timer and the top-level BRAM port muxes that decode the stage code.
//   - stage_e            : 3-bit state / stage code driven on the stage port
//   - CNT_W              : width of the per-stage cycle counter
//   - GAP_CYCLES_DEF     : default idle gap between consecutive stages
//   - TIMEOUT_CYCLES_DEF : default per-stage watchdog limit
`timescale 1ns/1ps
package imgproc_pkg;

   localparam int CNT_W              = 24;
   localparam int GAP_CYCLES_DEF     = 2;
   localparam int TIMEOUT_CYCLES_DEF = 1000000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RX   = 3'd1,
      ST_PAD  = 3'd2,
      ST_CONV = 3'd3,
      ST_TX   = 3'd4,
      ST_GAP  = 3'd5,
      ST_DONE = 3'd6,
      ST_ERR  = 3'd7
   } stage_e;

   // True for the four states in which a stage engine is enabled.
   function automatic logic is_work_stage(input stage_e s);
      return (s == ST_RX) || (s == ST_PAD) || (s == ST_CONV) || (s == ST_TX);
   endfunction

   // Stage that follows s in the fixed RX->PAD->CONV->TX order.
   function automatic stage_e following_stage(input stage_e s);
      case (s)
         ST_RX:   return ST_PAD;
         ST_PAD:  return ST_CONV;
         ST_CONV: return ST_TX;
         default: return ST_DONE;
      endcase
   endfunction

endpackage

// File: rtl/image_pipeline_sequencer_stage_timer.sv
// stage_timer: clearable up-counter with terminal-count flag, used as the
// per-stage watchdog of the image pipeline sequencer.
//   clk      in  : clock, rising edge
//   reset_n  in  : synchronous active-low reset
//   i_clr    in  : clear counter to zero (has priority over i_en)
//   i_en     in  : count this cycle
//   o_cnt    out : current count
//   o_tc     out : high while counting and the count equals TC
`timescale 1ns/1ps
module stage_timer
   import imgproc_pkg::*;
#(
   parameter int             W  = CNT_W,
   parameter logic [W-1:0]   TC = '1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = i_en && (r_cnt == TC);

endmodule

// File: rtl/image_pipeline_sequencer.sv
// image_pipeline_sequencer: runs the RX -> PAD -> CONV -> TX stage engines in
// order, one at a time, with an idle gap between stages and a per-stage
// watchdog.
//   clk                 in  : clock, rising edge
//   reset_n             in  : synchronous active-low reset
//   start               in  : one-cycle request to run the pipeline
//   skip_rx             in  : with start, begin at PAD (image already in BRAM)
//   abort               in  : level, return to IDLE
//   rx/pad/conv/tx_done in  : level completion flags from the stage engines
//   en_rx/pad/conv/tx   out : registered stage enables, at most one high
//   stage               out : state code (0 IDLE .. 7 ERR), drives BRAM muxes
//   busy                out : a stage or gap is in progress
//   done                out : one-cycle pulse after TX completes
//   error               out : sticky watchdog error
//   err_stage           out : stage code that timed out, 0 when no error
`timescale 1ns/1ps
module image_pipeline_sequencer
   import imgproc_pkg::*;
#(
   parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       skip_rx,
   input  logic       abort,
   input  logic       rx_done,
   input  logic       pad_done,
   input  logic       conv_done,
   input  logic       tx_done,
   output logic       en_rx,
   output logic       en_pad,
   output logic       en_conv,
   output logic       en_tx,
   output logic [2:0] stage,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [2:0] err_stage
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   // GAP_CYCLES of 0 or 1 both give a single gap cycle: the enable of the
   // finished stage always drops for at least one cycle.
   localparam logic [CNT_W-1:0] GAP_LAST =
      (GAP_CYCLES <= 1) ? '0 : CNT_W'(GAP_CYCLES - 1);

   stage_e           r_state;
   stage_e           w_state_nxt;
   stage_e           r_next_stage;
   stage_e           w_next_stage_nxt;
   logic [2:0]       r_err_stage;
   logic [2:0]       w_err_stage_nxt;
   logic [CNT_W-1:0] r_gap_cnt;
   logic [CNT_W-1:0] w_stage_cnt;
   logic             w_timeout;
   logic             w_stage_active;
   logic             w_done_sel;
   logic             r_en_rx;
   logic             r_en_pad;
   logic             r_en_conv;
   logic             r_en_tx;
   logic             r_busy;
   logic             r_done;
   logic             r_error;

   assign w_stage_active = is_work_stage(r_state);

   // Held clear outside the work stages, so the count is 0 on the first
   // enabled cycle of every stage.
   stage_timer #(
      .W  (CNT_W),
      .TC (TIMEOUT_LAST)
   ) u_stage_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (!w_stage_active),
      .i_en    (w_stage_active),
      .o_cnt   (w_stage_cnt),
      .o_tc    (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (!reset_n || (r_state != ST_GAP)) begin
         r_gap_cnt <= '0;
      end else begin
         r_gap_cnt <= r_gap_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_next_stage_nxt = r_next_stage;
      w_err_stage_nxt  = r_err_stage;
      w_done_sel       = 1'b0;

      // Only the active stage's flag is looked at.
      case (r_state)
         ST_RX:   w_done_sel = rx_done;
         ST_PAD:  w_done_sel = pad_done;
         ST_CONV: w_done_sel = conv_done;
         ST_TX:   w_done_sel = tx_done;
         default: w_done_sel = 1'b0;
      endcase

      case (r_state)
         ST_IDLE, ST_ERR: begin
            if (start) begin
               w_state_nxt     = skip_rx ? ST_PAD : ST_RX;
               w_err_stage_nxt = '0;
            end
         end
         ST_RX, ST_PAD, ST_CONV, ST_TX: begin
            // A done flag left high from a previous run is not trusted on
            // the first enabled cycle; done beats a simultaneous timeout.
            if (w_done_sel && (w_stage_cnt != '0)) begin
               if (r_state == ST_TX) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt      = ST_GAP;
                  w_next_stage_nxt = following_stage(r_state);
               end
            end else if (w_timeout) begin
               w_state_nxt     = ST_ERR;
               w_err_stage_nxt = r_state;
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_state_nxt = r_next_stage;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase

      if (abort) begin
         w_state_nxt      = ST_IDLE;
         w_next_stage_nxt = ST_RX;
         w_err_stage_nxt  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_next_stage <= ST_RX;
         r_err_stage  <= '0;
         r_en_rx      <= 1'b0;
         r_en_pad     <= 1'b0;
         r_en_conv    <= 1'b0;
         r_en_tx      <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_next_stage <= w_next_stage_nxt;
         r_err_stage  <= w_err_stage_nxt;
         r_en_rx      <= (w_state_nxt == ST_RX);
         r_en_pad     <= (w_state_nxt == ST_PAD);
         r_en_conv    <= (w_state_nxt == ST_CONV);
         r_en_tx      <= (w_state_nxt == ST_TX);
         r_busy       <= is_work_stage(w_state_nxt) || (w_state_nxt == ST_GAP);
         r_done       <= (w_state_nxt == ST_DONE);
         r_error      <= (w_state_nxt == ST_ERR);
      end
   end

   assign en_rx     = r_en_rx;
   assign en_pad    = r_en_pad;
   assign en_conv   = r_en_conv;
   assign en_tx     = r_en_tx;
   assign stage     = r_state;
   assign busy      = r_busy;
   assign done      = r_done;
   assign error     = r_error;
   assign err_stage = r_err_stage;

endmodule

// File: tb/tb_image_pipeline_sequencer.sv
`timescale 1ns/1ps
module tb_image_pipeline_sequencer;

   localparam int G = 2;
   localparam int T = 16;
   localparam int N = 80;

   logic       clk = 1'b0;
   logic       reset_n, start, skip_rx, abort;
   logic       rx_done, pad_done, conv_done, tx_done;
   logic       en_rx, en_pad, en_conv, en_tx;
   logic [2:0] stage;
   logic       busy, done, error;
   logic [2:0] err_stage;

   int n_total = 0;
   int n_bad   = 0;
   int exp_code [N];
   int exp_es   [N];

   typedef struct {
      bit skip;
      int d0, d1, d2, d3;
      int ab;
      int x_first;
      int x_encnt;
      int x_done;
      int x_err;
   } vec_t;
   vec_t tbl [8];

   always #5 clk = ~clk;

   image_pipeline_sequencer #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .skip_rx(skip_rx), .abort(abort),
      .rx_done(rx_done), .pad_done(pad_done), .conv_done(conv_done), .tx_done(tx_done),
      .en_rx(en_rx), .en_pad(en_pad), .en_conv(en_conv), .en_tx(en_tx),
      .stage(stage), .busy(busy), .done(done), .error(error), .err_stage(err_stage)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int expv);
      n_total++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // Expected output vector from a stage code: {stage, en x4, busy, done, error, err_stage}
   function automatic logic [12:0] mkvec(input int code, input int es);
      logic [12:0] v;
      v[12:10] = 3'(code);
      v[9]     = (code == 1);
      v[8]     = (code == 2);
      v[7]     = (code == 3);
      v[6]     = (code == 4);
      v[5]     = (code >= 1) && (code <= 5);
      v[4]     = (code == 6);
      v[3]     = (code == 7);
      v[2:0]   = (code == 7) ? 3'(es) : 3'd0;
      return v;
   endfunction

   function automatic logic [12:0] dutvec();
      return {stage, en_rx, en_pad, en_conv, en_tx, busy, done, error, err_stage};
   endfunction

   // Timeline model: start sampled in cycle 0; each stage with done delay d
   // stays enabled max(d,1)+1 cycles, or T cycles then ERR if that exceeds T-1.
   task automatic build(input bit skip, input int d [4], input int ab);
      int t, s, e, len;
      bit fin;
      for (int j = 0; j < N; j++) begin
         exp_code[j] = 0;
         exp_es[j]   = 0;
      end
      t   = 1;
      s   = skip ? 2 : 1;
      fin = 1'b0;
      while (!fin) begin
         e   = (d[s-1] < 1) ? 1 : d[s-1];
         len = (e <= T - 1) ? e + 1 : T;
         for (int k = 0; k < len; k++) exp_code[t+k] = s;
         t += len;
         if (e > T - 1) begin
            for (int j = t; j < N; j++) begin
               exp_code[j] = 7;
               exp_es[j]   = s;
            end
            fin = 1'b1;
         end else if (s == 4) begin
            exp_code[t] = 6;
            fin = 1'b1;
         end else begin
            for (int k = 0; k < G; k++) exp_code[t+k] = 5;
            t += G;
            s++;
         end
      end
      if (ab >= 0) begin
         for (int j = ab + 1; j < N; j++) begin
            exp_code[j] = 0;
            exp_es[j]   = 0;
         end
      end
   endtask

   task automatic run(input bit skip, input int d0, input int d1, input int d2, input int d3,
                      input int ab, output int first_stage, output int en_cnt,
                      output int done_cyc, output int err_end);
      int d [4];
      int ecnt [4];
      logic [3:0] prev_en, en_now, dn;
      bit busy_e;
      d = '{d0, d1, d2, d3};
      ecnt = '{0, 0, 0, 0};
      build(skip, d, ab);
      first_stage = 0;
      en_cnt      = 0;
      done_cyc    = -1;
      err_end     = 0;
      prev_en     = '0;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("cyc%0d", i), int'(dutvec()), int'(mkvec(exp_code[i], exp_es[i])));
         if (i == 1) first_stage = int'(stage);
         if (en_rx | en_pad | en_conv | en_tx) en_cnt++;
         if (done && (done_cyc < 0)) done_cyc = i;
         if (i == N - 1) err_end = int'(err_stage);
         // Stage engines: own done rises d cycles after enable; junk otherwise.
         en_now = {en_tx, en_conv, en_pad, en_rx};
         for (int s = 0; s < 4; s++) begin
            if (en_now[s]) begin
               ecnt[s] = prev_en[s] ? ecnt[s] + 1 : 0;
               dn[s]   = (ecnt[s] >= d[s]);
            end else begin
               dn[s] = 1'($urandom_range(0, 1));
            end
         end
         prev_en   = en_now;
         rx_done   = dn[0];
         pad_done  = dn[1];
         conv_done = dn[2];
         tx_done   = dn[3];
         busy_e    = (exp_code[i] >= 1) && (exp_code[i] <= 5);
         start     = (i == 0) || (busy_e && ($urandom_range(0, 3) == 0));
         skip_rx   = (i == 0) ? skip : 1'($urandom_range(0, 1));
         abort     = (i == ab);
         tick();
      end
      start = 1'b0; abort = 1'b1;
      rx_done = 1'b0; pad_done = 1'b0; conv_done = 1'b0; tx_done = 1'b0;
      tick();
      abort = 1'b0;
      chk("cleanup_idle", int'(dutvec()), 0);
   endtask

   initial begin
      int fs, ec, dc, er, cnt;
      bit sk;
      int r0, r1, r2, r3, ab;

      tbl[0] = '{1'b0, 4, 4, 4, 4, -1, 1, 20, 27, 0};
      tbl[1] = '{1'b1, 4, 4, 4, 4, -1, 2, 15, 20, 0};
      tbl[2] = '{1'b0, 4, 4, 99, 4, -1, 1, 26, -1, 3};
      tbl[3] = '{1'b0, 4, 4, 4, 4, 12, 1, 10, -1, 0};
      tbl[4] = '{1'b0, 0, 0, 0, 0, -1, 1, 8, 15, 0};
      tbl[5] = '{1'b0, 1, 1, 1, 15, -1, 1, 22, 29, 0};
      tbl[6] = '{1'b0, 1, 16, 1, 1, -1, 1, 18, -1, 2};
      tbl[7] = '{1'b0, 16, 1, 1, 1, -1, 1, 16, -1, 1};

      reset_n = 1'b0; start = 1'b0; skip_rx = 1'b0; abort = 1'b0;
      rx_done = 1'b0; pad_done = 1'b0; conv_done = 1'b0; tx_done = 1'b0;
      tick();
      tick();
      chk("reset_state", int'(dutvec()), 0);
      reset_n = 1'b1;
      tick();
      chk("idle_after_reset", int'(dutvec()), 0);

      // abort beats start in IDLE
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("abort_beats_start", int'(dutvec()), 0);

      for (int v = 0; v < 8; v++) begin
         run(tbl[v].skip, tbl[v].d0, tbl[v].d1, tbl[v].d2, tbl[v].d3, tbl[v].ab, fs, ec, dc, er);
         chk($sformatf("tbl%0d_first_stage", v), fs, tbl[v].x_first);
         chk($sformatf("tbl%0d_en_cycles", v), ec, tbl[v].x_encnt);
         chk($sformatf("tbl%0d_done_cycle", v), dc, tbl[v].x_done);
         chk($sformatf("tbl%0d_err_stage", v), er, tbl[v].x_err);
      end

      // rx_done stuck high before start; start pulses during the run
      rx_done = 1'b1;
      tick();
      tick();
      start = 1'b1;
      tick();
      chk("stuck_rx_c1", int'(dutvec()), int'(mkvec(1, 0)));
      tick();
      chk("stuck_rx_c2", int'(dutvec()), int'(mkvec(1, 0)));
      start = 1'b0;
      tick();
      chk("stuck_rx_gap", int'(dutvec()), int'(mkvec(5, 0)));
      rx_done = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("stuck_rx_abort", int'(dutvec()), 0);

      // RX timeout, error held, restart from ERR
      start = 1'b1; skip_rx = 1'b0;
      tick();
      start = 1'b0;
      cnt = 0;
      for (int k = 1; k <= 16; k++) begin
         if (en_rx) cnt++;
         tick();
      end
      chk("rx_timeout_len", cnt, 16);
      chk("rx_timeout_err", int'(dutvec()), int'(mkvec(7, 1)));
      tick();
      tick();
      tick();
      chk("err_held", int'(dutvec()), int'(mkvec(7, 1)));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_from_err", int'(dutvec()), int'(mkvec(1, 0)));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("restart_abort", int'(dutvec()), 0);

      // reset in the middle of TX
      skip_rx = 1'b1; start = 1'b1;
      rx_done = 1'b1; pad_done = 1'b1; conv_done = 1'b1; tx_done = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      chk("tx_reached", int'(dutvec()), int'(mkvec(4, 0)));
      reset_n = 1'b0;
      tick();
      chk("reset_mid_tx", int'(dutvec()), 0);
      reset_n = 1'b1; skip_rx = 1'b0;
      rx_done = 1'b0; pad_done = 1'b0; conv_done = 1'b0; tx_done = 1'b0;
      tick();
      chk("idle_after_mid_reset", int'(dutvec()), 0);

      // randomized scenarios against the timeline model
      for (int r = 0; r < 30; r++) begin
         sk = ($urandom_range(0, 3) == 0);
         r0 = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 6)) : int'($urandom_range(13, 17));
         r1 = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 6)) : int'($urandom_range(13, 17));
         r2 = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 6)) : int'($urandom_range(13, 17));
         r3 = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 6)) : int'($urandom_range(13, 17));
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 45)) : -1;
         run(sk, r0, r1, r2, r3, ab, fs, ec, dc, er);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/image_pipeline_sequencer.md
IMAGE_PIPELINE_SEQUENCER -- requirements
Module: image_pipeline_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 2: idle cycles with all stage enables low between consecutive stages.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum cycles any single stage may stay enabled; legal range 2..2^24-1.
REQ-003 Port clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port reset_n  input  1  synchronous, active-low reset.
REQ-005 Port start  input  1  single-cycle request to run the full pipeline.
REQ-006 Port skip_rx  input  1  sampled with start; 1 = reuse image already in original BRAM and begin at PAD.
REQ-007 Port abort  input  1  level; returns the sequencer to IDLE.
REQ-008 Ports rx_done, pad_done, conv_done, tx_done  input  1 each  level completion flags from the four stage engines.
REQ-009 Ports en_rx, en_pad, en_conv, en_tx  output  1 each  registered stage enables, at most one high; an engine is held in reset while its enable is low.
REQ-010 Port stage  output  3  current-state code: 0 IDLE, 1 RX, 2 PAD, 3 CONV, 4 TX, 5 GAP, 6 DONE, 7 ERR; the top level drives BRAM port muxes from this code.
REQ-011 Ports busy, done, error  output  1 each  busy = stage not IDLE/DONE/ERR; done = one-cycle pulse; error = sticky.
REQ-012 Port err_stage  output  3  stage code (1..4) that timed out; 0 when error low.

Function
REQ-013 FSM states IDLE, RX, PAD, CONV, TX, GAP, DONE, ERR; one register next_stage records the stage entered on GAP exit.
REQ-014 IDLE: start=1 and abort=0 -> RX next cycle (PAD if skip_rx=1); en_* goes high on that next cycle (1-cycle latency).
REQ-015 Stage exit: the stage's own done flag is ignored in the first enabled cycle (stage_cnt=0) and sampled from stage_cnt>=1; done high -> GAP next cycle, enable low that cycle.
REQ-016 Order RX->PAD->CONV->TX; done flags of non-active stages are ignored.
REQ-017 GAP lasts exactly GAP_CYCLES cycles; GAP_CYCLES=0 skips GAP (enable drops for exactly 1 cycle, next enable rises the following cycle).
REQ-018 TX done -> DONE for one cycle with done=1, then IDLE.
REQ-019 stage_cnt, 24-bit, clears on entry to each stage and increments each enabled cycle; stage_cnt=TIMEOUT_CYCLES-1 with done low -> ERR next cycle.
REQ-020 ERR: all enables low, error=1, err_stage held; leaves only on start (clears error, behaves as IDLE start) or reset.
REQ-021 abort=1 in any state -> IDLE next cycle, enables low, no done pulse, error cleared.
REQ-022 Simultaneous: abort beats start and beats any done flag; timeout and done in the same cycle -> done wins.
REQ-023 start while busy or in DONE is ignored; start is not queued.
REQ-024 All outputs registered; no combinational path input->output.

Reset
REQ-025 reset_n=0 at a clock edge -> IDLE, en_*=0, stage=0, busy=0, done=0, error=0, err_stage=0, stage_cnt=0, next_stage=RX.
REQ-026 Reset mid-stage has the same effect as abort and takes precedence over all inputs.

Structure
REQ-027 State codes, GAP_CYCLES default and TIMEOUT_CYCLES default live in shared package imgproc_pkg, which the top-level BRAM mux also imports.
REQ-028 One sub-module, stage_timer (24-bit clearable counter with terminal-count flag); otherwise a single FSM.

Verification (GAP_CYCLES=2, TIMEOUT_CYCLES=16)
REQ-029 start at cycle 0, each done raised 5 cycles after its enable -> en_rx 1..5, en_pad 8..12, en_conv 15..19, en_tx 22..26, done=1 at cycle 27, then IDLE.
REQ-030 start with skip_rx=1 -> en_rx never high, en_pad high at cycle 1.
REQ-031 conv_done held low -> en_conv high 16 cycles, then error=1, err_stage=3, enables 0; a later start restarts at RX with error cleared.
REQ-032 abort during PAD, simultaneous with pad_done -> IDLE next cycle, en_conv never rises, done never pulses.
REQ-033 rx_done stuck high from before start -> ignored on first RX cycle, exit on second (en_rx high exactly 2 cycles); start pulses during run ignored.
REQ-034 reset_n=0 mid-TX -> all outputs at reset values on the following cycle.
